// File: rtl/booth_radix_4_mult.sv
// Iterative Booth radix-4 multiplier: retires two multiplier bits per enabled cycle,
// signed or unsigned per operation, with start/enable/done/busy handshake.
module booth_radix_4_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 enable,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multA,
  input  logic [WIDTH-1:0]     multB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int W2 = WIDTH + 2;
  localparam int N  = W2 / 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q;
  logic [W2-1:0]        m_q;
  logic [W2-1:0]        q_q;
  logic [W2:0]          a_q;
  logic                 qm1_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   prod_q;

  // Two extra bits let unsigned operands stay positive under Booth recoding.
  logic [W2-1:0] a_ext, b_ext;
  assign a_ext = signed_mode ? {{2{multA[WIDTH-1]}}, multA} : {2'b00, multA};
  assign b_ext = signed_mode ? {{2{multB[WIDTH-1]}}, multB} : {2'b00, multB};

  logic [W2:0]   m1, m2, addend, sum_d;
  logic [2:0]    trip;
  logic [2*W2+1:0] shifted;
  logic [W2:0]   a_d;
  logic [W2-1:0] q_d;
  logic          qm1_d;
  logic [2*WIDTH-1:0] prod_d;

  assign m1   = {m_q[W2-1], m_q};
  assign m2   = {m_q, 1'b0};
  assign trip = {q_q[1:0], qm1_q};

  always_comb begin
    addend = '0;
    case (trip)
      3'b001, 3'b010: addend = m1;
      3'b011:         addend = m2;
      3'b100:         addend = -m2;
      3'b101, 3'b110: addend = -m1;
      default:        addend = '0;
    endcase
  end

  assign sum_d   = a_q + addend;
  assign shifted = $signed({sum_d, q_q, qm1_q}) >>> 2;
  assign a_d     = shifted[2*W2+1:W2+1];
  assign q_d     = shifted[W2:1];
  assign qm1_d   = shifted[0];
  assign prod_d  = {a_d[WIDTH-3:0], q_d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            m_q     <= a_ext;
            q_q     <= b_ext;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= N_CNT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (enable) begin
            a_q   <= a_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_q - ONE_CNT;
            // Final iteration publishes the post-shift product on the same edge.
            if (cnt_q == ONE_CNT) begin
              prod_q  <= prod_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_radix_4_mult.sv
// Directed self-checking bench for booth_radix_4_mult at WIDTH=8.
module tb_booth_radix_4_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, enable, signed_mode;
  logic [7:0]  multA, multB;
  logic        busy, done;
  logic [15:0] product;

  int tests = 0;
  int fails = 0;

  booth_radix_4_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable),
    .signed_mode(signed_mode), .multA(multA), .multB(multB),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic s, input logic en);
    @(negedge clk);
    multA = a; multB = b; signed_mode = s; start = 1'b1; enable = en;
    @(negedge clk);
    start = 1'b0; enable = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      enable = 1'b1;
      @(negedge clk);
    end
    enable = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b0; start = 1'b0; enable = 1'b0; signed_mode = 1'b0;
    multA = '0; multB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_prod", {16'd0, product}, 32'd0);
    rst = 1'b1;

    // 15*3 unsigned
    go(8'd15, 8'd3, 1'b0, 1'b0);
    chk("t1_busy_start", {31'd0, busy}, 32'd1);
    run(4);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    run(1);
    chk("t1_prod", {16'd0, product}, 32'd45);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    run(3);
    chk("t1_hold_done", {31'd0, done}, 32'd1);
    chk("t1_hold_prod", {16'd0, product}, 32'd45);

    go(8'hFF, 8'hFF, 1'b0, 1'b0);
    run(5);
    chk("t2_fullscale", {16'd0, product}, 32'h0000FE01);

    // signed_mode flipped after start must not matter
    go(8'hF9, 8'h08, 1'b1, 1'b0);
    signed_mode = 1'b0; multA = 8'h01;
    run(5);
    chk("t3_neg7x8", {16'd0, product}, 32'h0000FFC8);
    go(8'h80, 8'h80, 1'b1, 1'b0);
    run(5);
    chk("t3_m128xm128", {16'd0, product}, 32'h00004000);
    go(8'h7F, 8'h80, 1'b1, 1'b0);
    run(5);
    chk("t3_127xm128", {16'd0, product}, 32'h0000C080);

    // stall pattern 1,0,0,1,1,0,1,1
    go(8'd15, 8'd3, 1'b0, 1'b0);
    pat = 8'b1101_1001;
    for (int i = 0; i < 8; i++) begin
      enable = pat[i];
      @(negedge clk);
      if (i < 7) begin
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_notdone", {31'd0, done}, 32'd0);
        chk("t4_prod_held", {16'd0, product}, 32'h0000C080);
      end
    end
    enable = 1'b0;
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_prod", {16'd0, product}, 32'd45);

    // start mid-RUN ignored
    go(8'd5, 8'd6, 1'b0, 1'b0);
    run(2);
    go(8'd100, 8'd100, 1'b0, 1'b0);
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    run(3);
    chk("t5_ignored", {16'd0, product}, 32'd30);
    chk("t5_done", {31'd0, done}, 32'd1);

    // back-to-back from DONE with start+enable together: start wins
    go(8'd7, 8'd8, 1'b0, 1'b1);
    chk("t5_done_drop", {31'd0, done}, 32'd0);
    chk("t5_busy_b2b", {31'd0, busy}, 32'd1);
    run(4);
    chk("t5_b2b_early", {31'd0, done}, 32'd0);
    run(1);
    chk("t5_b2b_prod", {16'd0, product}, 32'd56);

    // async reset mid-operation
    go(8'd15, 8'd3, 1'b0, 1'b0);
    run(2);
    enable = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_prod", {16'd0, product}, 32'd0);
    @(negedge clk);
    enable = 1'b0; rst = 1'b1;
    go(8'd7, 8'd8, 1'b1, 1'b0);
    run(5);
    chk("t6_after", {16'd0, product}, 32'd56);
    chk("t6_after_done", {31'd0, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
